loop_nest_issue_sched: RTL and testbench

//  Issue scheduler for an NDIMS-deep loop nest: after start, pulses issue once every II

---
 rtl/loop_nest_pkg.sv | 17 +
 rtl/nest_dim_counter.sv | 56 +++++
 rtl/loop_nest_issue_sched.sv | 133 +++++++++++++
 tb/tb_loop_nest_issue_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/loop_nest_pkg.sv
// loop_nest_pkg -- shared types and helpers for the loop-nest issue scheduler.
//   state_t : scheduler FSM encoding (IDLE / RUN / FIN)
//   ii_eff  : maps an initiation interval of 0 onto 1, otherwise passes it through
package loop_nest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Callers cast their narrower II into and out of this 32-bit form.
    function automatic logic [31:0] ii_eff(input logic [31:0] ii);
        return (ii == 32'd0) ? 32'd1 : ii;
    endfunction

endpackage

// File: rtl/nest_dim_counter.sv
// nest_dim_counter -- one dimension of the loop-nest odometer.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : latch trip_i and clear the index (accepted start)
//   trip_i    : trip count for this dimension
//   inc_i     : advance the index by one (issue or carry from the dimension below)
//   idx_o     : current index
//   last_o    : index is at trip-1 (wrap point)
//   carry_o   : this increment wraps, so the next-outer dimension must advance
module nest_dim_counter
    import loop_nest_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] trip_i,
    input  logic          inc_i,
    output logic [CW-1:0] idx_o,
    output logic          last_o,
    output logic          carry_o
);

    logic [CW-1:0] trip_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] idx_d;

    assign last_o  = (idx_q == trip_q - CW'(1));
    assign carry_o = inc_i && last_o;
    assign idx_o   = idx_q;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        idx_d = idx_q;
        if (load_i) begin
            idx_d = '0;
        end else if (inc_i) begin
            // Wrap happens before the counter could ever reach 2^CW-1 + 1.
            idx_d = last_o ? '0 : idx_q + CW'(1);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            trip_q <= '0;
            idx_q  <= '0;
        end else begin
            idx_q <= idx_d;
            if (load_i) begin
                trip_q <= trip_i;
            end
        end
    end

endmodule

// File: rtl/loop_nest_issue_sched.sv
// loop_nest_issue_sched -- issues one iteration every II cycles over an NDIMS-deep
// loop nest (dim 0 innermost) with runtime trip counts, stall and a done pulse.
//   clk, rst       : clock, synchronous active-high reset
//   start_i        : launch the nest (honoured only in IDLE)
//   trip_counts_i  : trip count per dim, dim d at [d*CW +: CW]; sampled on accepted start
//   ii_i           : initiation interval, 0 treated as 1; sampled on accepted start
//   stall_i        : freeze the scheduler this cycle
//   busy_o         : nest in progress
//   issue_o        : one iteration issued this cycle
//   idx_o          : index of the issued iteration
//   last_o         : per-dim "index is trip-1" flags, meaningful with issue_o
//   done_o         : one-cycle pulse after the final issue (or after a zero-trip start)
//   stall_cycles_o : only with LOOP_NEST_ISSUE_SCHED_PERF_EN defined; saturating count of
//                    busy&&stall cycles, cleared on accepted start
module loop_nest_issue_sched
    import loop_nest_pkg::*;
#(
    parameter int NDIMS = 3,
    parameter int CW    = 16,
    parameter int IIW   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [NDIMS*CW-1:0] trip_counts_i,
    input  logic [IIW-1:0]      ii_i,
    input  logic                stall_i,
    output logic                busy_o,
    output logic                issue_o,
    output logic [NDIMS*CW-1:0] idx_o,
    output logic [NDIMS-1:0]    last_o,
    output logic                done_o
`ifdef LOOP_NEST_ISSUE_SCHED_PERF_EN
    ,
    output logic [31:0]         stall_cycles_o
`endif
);

    state_t           state_q;
    logic [IIW-1:0]   ii_cnt_q;
    logic [IIW-1:0]   ii_eff_q;
    logic             issue;
    logic             start_accept;
    logic             any_zero_trip;
    logic [NDIMS-1:0] carry;

    assign start_accept = (state_q == ST_IDLE) && start_i;
    assign issue        = (state_q == ST_RUN) && !stall_i && (ii_cnt_q == '0);

    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_FIN);
    assign issue_o = issue;

    always_comb begin
        any_zero_trip = 1'b0;
        for (int d = 0; d < NDIMS; d++) begin
            if (trip_counts_i[d*CW +: CW] == '0) begin
                any_zero_trip = 1'b1;
            end
        end
    end

    // Odometer: dim 0 advances on issue, each higher dim on the carry of the one below.
    for (genvar d = 0; d < NDIMS; d++) begin : g_dim
        logic inc;
        if (d == 0) begin : g_first
            assign inc = issue;
        end else begin : g_next
            assign inc = carry[d-1];
        end

        nest_dim_counter #(.CW(CW)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .load_i  (start_accept),
            .trip_i  (trip_counts_i[d*CW +: CW]),
            .inc_i   (inc),
            .idx_o   (idx_o[d*CW +: CW]),
            .last_o  (last_o[d]),
            .carry_o (carry[d])
        );
    end

    // The outermost carry fires exactly on the issue where every dim is at its last index.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ii_cnt_q <= '0;
            ii_eff_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        ii_cnt_q <= '0;
                        ii_eff_q <= IIW'(ii_eff(32'(ii_i)));
                        state_q  <= any_zero_trip ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!stall_i) begin
                        if (issue) begin
                            ii_cnt_q <= (ii_eff_q == IIW'(1)) ? '0 : IIW'(1);
                            if (carry[NDIMS-1]) begin
                                state_q <= ST_FIN;
                            end
                        end else begin
                            ii_cnt_q <= (ii_cnt_q == ii_eff_q - IIW'(1)) ? '0 : ii_cnt_q + IIW'(1);
                        end
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LOOP_NEST_ISSUE_SCHED_PERF_EN
    logic [31:0] stall_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else if (start_accept) begin
            stall_cycles_q <= '0;
        end else if (busy_o && stall_i && (stall_cycles_q != '1)) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
`endif

endmodule

// File: tb/tb_loop_nest_issue_sched.sv
module tb_loop_nest_issue_sched;

    localparam int NDIMS = 2;
    localparam int CW    = 8;
    localparam int IIW   = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [NDIMS*CW-1:0] trip_counts = '0;
    logic [IIW-1:0]      ii_in = '0;
    logic                stall = 1'b0;
    logic                busy;
    logic                issue;
    logic [NDIMS*CW-1:0] idx;
    logic [NDIMS-1:0]    last;
    logic                done;
`ifdef LOOP_NEST_ISSUE_SCHED_PERF_EN
    logic [31:0]         stall_cycles;
`endif

    loop_nest_issue_sched #(.NDIMS(NDIMS), .CW(CW), .IIW(IIW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .trip_counts_i (trip_counts),
        .ii_i          (ii_in),
        .stall_i       (stall),
        .busy_o        (busy),
        .issue_o       (issue),
        .idx_o         (idx),
        .last_o        (last),
        .done_o        (done)
`ifdef LOOP_NEST_ISSUE_SCHED_PERF_EN
        ,
        .stall_cycles_o(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NDIMS*CW-1:0] idx;
        logic [NDIMS-1:0]    last;
        int                  cyc;
    } exp_t;

    exp_t sb[$];
    int   done_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_issue  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives an accepted start and pushes the full expected issue/done schedule.
    // Issues with index >= defer_idx are pushed back by defer_n stalled cycles.
    task automatic launch(input logic [CW-1:0] t0, input logic [CW-1:0] t1,
                          input logic [IIW-1:0] ii, input int defer_idx,
                          input int defer_n, output int c0);
        int   iie;
        int   k;
        int   last_cyc;
        exp_t e;
        trip_counts = {t1, t0};
        ii_in       = ii;
        start       = 1'b1;
        c0          = cyc;
        iie         = (ii == '0) ? 1 : int'(ii);
        k           = 0;
        last_cyc    = c0;
        for (int d1 = 0; d1 < int'(t1); d1++) begin
            for (int d0 = 0; d0 < int'(t0); d0++) begin
                e.idx  = {CW'(d1), CW'(d0)};
                e.last = {d1 == int'(t1) - 1, d0 == int'(t0) - 1};
                e.cyc  = c0 + 1 + k * iie + ((defer_idx >= 0 && k >= defer_idx) ? defer_n : 0);
                last_cyc = e.cyc;
                sb.push_back(e);
                k++;
            end
        end
        done_q.push_back(last_cyc + 1);
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && done_q.size() == 0) break;
            tick();
        end
        check({tag, "_issues_left"}, sb.size(), 0);
        check({tag, "_done_left"}, done_q.size(), 0);
        tick();
        check({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 300; i++) begin
            if (cyc >= target) break;
            tick();
        end
    endtask

    // Scoreboard monitor: compares every issue and done against the queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (issue) begin
                n_issue++;
                check("busy_on_issue", busy, 1'b1);
                if (sb.size() == 0) begin
                    check("issue_unexpected", issue, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("issue_idx", idx, e.idx);
                    check("issue_last", last, e.last);
                    check("issue_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", done, 1'b0);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                    check("busy_on_done", busy, 1'b0);
                end
            end
        end
    end

    initial begin
        int c0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_issue", issue, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idx", idx, '0);
        check("rst_last", last, '0);
        tick();

        // 1: trips {3,2}, ii=1 -> 6 back-to-back issues
        launch(8'd3, 8'd2, 8'd1, -1, 0, c0);
        drain("t1");

        // 2: trips {2,2}, ii=3 -> issues 3 cycles apart
        launch(8'd2, 8'd2, 8'd3, -1, 0, c0);
        drain("t2");

        // 3: ii=2, stall on the cycle issue #1 is due -> deferred by one cycle
        launch(8'd2, 8'd2, 8'd2, 1, 1, c0);
        wait_cyc(c0 + 3);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        drain("t3");

        // 4a: zero trip in dim 1 -> no issue, done next cycle
        launch(8'd4, 8'd0, 8'd1, -1, 0, c0);
        drain("t4a");

        // 4b: ii=0 behaves as ii=1
        launch(8'd2, 8'd2, 8'd0, -1, 0, c0);
        drain("t4b");

        // 5: start during RUN ignored; rst after the 2nd issue
        n_issue = 0;
        launch(8'd3, 8'd2, 8'd2, -1, 0, c0);
        for (int i = 0; i < 50; i++) begin
            if (n_issue >= 1) break;
            @(posedge clk);
        end
        #1;
        trip_counts = {8'd1, 8'd1};
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (n_issue >= 2) break;
            @(posedge clk);
        end
        #1;
        check("t5_two_issues", n_issue, 2);
        rst = 1'b1;
        sb.delete();
        done_q.delete();
        tick();
        rst = 1'b0;
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_idx", idx, '0);
        check("t5_rst_done", done, 1'b0);
        repeat (5) tick();
        launch(8'd3, 8'd2, 8'd2, -1, 0, c0);
        drain("t5_replay");

`ifdef LOOP_NEST_ISSUE_SCHED_PERF_EN
        // 6: five stalled RUN cycles counted, cleared on the next accepted start
        launch(8'd3, 8'd2, 8'd1, 1, 5, c0);
        wait_cyc(c0 + 2);
        stall = 1'b1;
        repeat (5) tick();
        stall = 1'b0;
        drain("t6");
        check("t6_stall_cycles", stall_cycles, 32'd5);
        launch(8'd1, 8'd1, 8'd1, -1, 0, c0);
        check("t6_stall_clear", stall_cycles, 32'd0);
        drain("t6b");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
